// File: rtl/cnn_pkg.sv
// Shared fixed-point helpers and constants for the CNN datapath blocks.
package cnn_pkg;

    localparam bit ROUND_HALF_UP = 1'b1;

    function automatic int gamma_one(input int frac);
        return 1 << frac;
    endfunction

    function automatic int ch_idx_w(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

    // Clamp a sign-extended value into the signed range of 'width' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational requantise step: round, arithmetic shift, add bias, then clamp or wrap.
module fxp_round_sat import cnn_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int FRAC     = 4,
    parameter int ROUND    = 1,
    parameter int SATURATE = 1
) (
    input  logic signed [DATA_W+COEF_W-1:0] prod,
    input  logic signed [COEF_W-1:0]        bias,
    output logic signed [DATA_W-1:0]        result,
    output logic                            sat
);

    // One guard bit above the product keeps rounding and bias addition overflow-free.
    localparam int YW = DATA_W + COEF_W + 1;
    localparam logic signed [YW-1:0] RND = (ROUND != 0) ? YW'(64'sd1 <<< (FRAC - 1)) : '0;

    logic signed [YW-1:0] rounded;
    logic signed [YW-1:0] shifted;
    logic signed [YW-1:0] biased;
    logic signed [63:0]   wide;
    logic signed [63:0]   clamped;

    always_comb begin
        rounded = YW'(prod) + RND;
        shifted = rounded >>> FRAC;
        biased  = shifted + YW'(bias);
        wide    = 64'(biased);
        clamped = sat_signed(wide, DATA_W);
        if (SATURATE != 0) begin
            result = clamped[DATA_W-1:0];
            sat    = (clamped != wide);
        end else begin
            result = biased[DATA_W-1:0];
            sat    = 1'b0;
        end
    end

endmodule

// File: rtl/batchnorm_channel_affine.sv
// Per-channel batch-norm scale/shift with loadable gamma/beta and a 2-stage valid/ready pipeline.
module batchnorm_channel_affine import cnn_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int COEF_W   = 8,
    parameter int FRAC     = 4,
    parameter int CH       = 4,
    parameter int ROUND    = int'(ROUND_HALF_UP),
    parameter int SATURATE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_we,
    input  logic                       cfg_sel,
    input  logic [ch_idx_w(CH)-1:0]    cfg_ch,
    input  logic signed [COEF_W-1:0]   cfg_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [DATA_W-1:0]   in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [DATA_W-1:0]   out_data,
    output logic [ch_idx_w(CH)-1:0]    out_ch,
    output logic                       out_sat,
    output logic [15:0]                sat_cnt,
    input  logic                       sat_cnt_clr
);

    localparam int CW = ch_idx_w(CH);
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [COEF_W-1:0] GAMMA_RST = COEF_W'(gamma_one(FRAC));

    logic signed [COEF_W-1:0] gamma [CH];
    logic signed [COEF_W-1:0] beta  [CH];
    logic [CW-1:0]            ch_cnt;
    logic                     s1_valid;
    logic                     s2_valid;
    logic                     s1_ready;
    logic                     in_fire;
    logic signed [PW-1:0]     s1_prod;
    logic signed [COEF_W-1:0] s1_beta;
    logic [CW-1:0]            s1_ch;
    logic signed [DATA_W-1:0] rs_data;
    logic                     rs_sat;

    assign s1_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_ready;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                gamma[i] <= GAMMA_RST;
                beta[i]  <= '0;
            end
        end else if (cfg_we && (32'(cfg_ch) < CH)) begin
            if (cfg_sel) beta[cfg_ch]  <= cfg_data;
            else         gamma[cfg_ch] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ch_cnt <= '0;
        else if (in_fire) ch_cnt <= (in_last || ch_cnt == CW'(CH - 1)) ? '0 : ch_cnt + 1'b1;
    end

    // Coefficients are captured with the beat, so later writes never disturb beats in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_beta  <= '0;
            s1_ch    <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_fire) begin
                s1_prod <= PW'(in_data) * PW'(gamma[ch_cnt]);
                s1_beta <= beta[ch_cnt];
                s1_ch   <= ch_cnt;
            end
        end
    end

    fxp_round_sat #(
        .DATA_W  (DATA_W),
        .COEF_W  (COEF_W),
        .FRAC    (FRAC),
        .ROUND   (ROUND),
        .SATURATE(SATURATE)
    ) u_round_sat (
        .prod  (s1_prod),
        .bias  (s1_beta),
        .result(rs_data),
        .sat   (rs_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ch   <= '0;
            out_sat  <= 1'b0;
        end else if (s1_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= rs_data;
                out_ch   <= s1_ch;
                out_sat  <= rs_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_cnt <= '0;
        else if (sat_cnt_clr)
            sat_cnt <= '0;
        else if (s2_valid && out_ready && out_sat && sat_cnt != 16'hFFFF)
            sat_cnt <= sat_cnt + 16'd1;
    end

endmodule

// File: tb/tb_batchnorm_channel_affine.sv
// Directed bench for batchnorm_channel_affine; a second instance with ROUND=0 shares all inputs.
module tb_batchnorm_channel_affine;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_we;
    logic              cfg_sel;
    logic [1:0]        cfg_ch;
    logic signed [7:0] cfg_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic [1:0]        out_ch;
    logic              out_sat;
    logic [15:0]       sat_cnt;
    logic              sat_cnt_clr;

    logic              t_in_ready;
    logic              t_out_valid;
    logic signed [7:0] t_out_data;
    logic [1:0]        t_out_ch;
    logic              t_out_sat;
    logic [15:0]       t_sat_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    batchnorm_channel_affine #(
        .DATA_W(8), .COEF_W(8), .FRAC(4), .CH(4), .ROUND(1), .SATURATE(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_sat(out_sat), .sat_cnt(sat_cnt), .sat_cnt_clr(sat_cnt_clr)
    );

    batchnorm_channel_affine #(
        .DATA_W(8), .COEF_W(8), .FRAC(4), .CH(4), .ROUND(0), .SATURATE(1)
    ) dut_trunc (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data),
        .out_ch(t_out_ch), .out_sat(t_out_sat), .sat_cnt(t_sat_cnt), .sat_cnt_clr(sat_cnt_clr)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        cfg_we = 1'b0;
        sat_cnt_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write_coef(input logic sel, input logic [1:0] ch, input logic signed [7:0] val);
        @(negedge clk);
        cfg_sel = sel;
        cfg_ch = ch;
        cfg_data = val;
        cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // Presents one beat from a negedge and returns 1 time unit after the edge that accepted it.
    task automatic push(input logic signed [7:0] d, input logic l, input logic we);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        cfg_we = we;
        while (!(in_ready && t_in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            vec_cnt++;
            err_cnt++;
            $display("[TB] FAIL push_timeout: in_ready=%0b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic transact(input logic signed [7:0] d, input logic l, input logic we,
                            output logic signed [7:0] od, output logic [1:0] och,
                            output logic osat, output logic signed [7:0] otd,
                            output logic [1:0] otch, output int lat);
        int n = 0;
        out_ready = 1'b1;
        push(d, l, we);
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && t_out_valid) && n < 20);
        if (n >= 20) begin
            vec_cnt++;
            err_cnt++;
            $display("[TB] FAIL out_timeout: out_valid=%0b, expected 1", out_valid);
        end
        lat  = n;
        od   = out_data;
        och  = out_ch;
        osat = out_sat;
        otd  = t_out_data;
        otch = t_out_ch;
    endtask

    task automatic test_reset();
        logic signed [7:0] od, otd;
        logic [1:0] och, otch;
        logic osat;
        int lat;
        rst_n = 1'b0;
        #2;
        vec_cnt++;
        if ({out_valid, out_data, out_ch, out_sat, sat_cnt} !== 28'd0) begin
            err_cnt++;
            $display("[TB] FAIL reset_outputs: got v=%0b d=%0d ch=%0d sat=%0b cnt=%0d, expected all 0",
                     out_valid, out_data, out_ch, out_sat, sat_cnt);
        end
        do_reset();
        transact(8'sd25, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd25 || och !== 2'd0 || osat !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL default_25: got %0d ch%0d sat%0b, expected 25 ch0 sat0", od, och, osat);
        end
        vec_cnt++;
        if (lat !== 2) begin
            err_cnt++;
            $display("[TB] FAIL latency: got %0d cycles, expected 2", lat);
        end
        transact(-8'sd7, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== -8'sd7 || och !== 2'd1 || osat !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL default_m7: got %0d ch%0d sat%0b, expected -7 ch1 sat0", od, och, osat);
        end
    endtask

    task automatic test_coef();
        logic signed [7:0] od, otd;
        logic [1:0] och, otch;
        logic osat;
        int lat;
        write_coef(1'b0, 2'd1, 8'sh18);
        write_coef(1'b1, 2'd1, 8'sd3);
        transact(8'sd0, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd0 || och !== 2'd0) begin
            err_cnt++;
            $display("[TB] FAIL ch0_zero: got %0d ch%0d, expected 0 ch0", od, och);
        end
        transact(8'sd10, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd18 || och !== 2'd1 || otch !== 2'd1) begin
            err_cnt++;
            $display("[TB] FAIL ch1_10: got %0d ch%0d, expected 18 ch1", od, och);
        end
        transact(8'sd0, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        transact(8'sd3, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd8) begin
            err_cnt++;
            $display("[TB] FAIL ch1_3_round: got %0d, expected 8", od);
        end
        vec_cnt++;
        if (otd !== 8'sd7) begin
            err_cnt++;
            $display("[TB] FAIL ch1_3_trunc: got %0d, expected 7", otd);
        end
        transact(8'sd0, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        transact(-8'sd3, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== -8'sd1) begin
            err_cnt++;
            $display("[TB] FAIL ch1_m3_round: got %0d, expected -1", od);
        end
        vec_cnt++;
        if (otd !== -8'sd2) begin
            err_cnt++;
            $display("[TB] FAIL ch1_m3_trunc: got %0d, expected -2", otd);
        end
    endtask

    task automatic test_saturation();
        logic signed [7:0] od, otd;
        logic [1:0] och, otch;
        logic osat;
        int lat;
        write_coef(1'b0, 2'd0, 8'sh20);
        transact(8'sd100, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd127 || osat !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL sat_pos: got %0d sat%0b, expected 127 sat1", od, osat);
        end
        transact(-8'sd100, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== -8'sd128 || osat !== 1'b1 || otd !== -8'sd128 || t_out_sat !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL sat_neg: got %0d sat%0b trunc %0d, expected -128 sat1", od, osat, otd);
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if (sat_cnt !== 16'd2 || t_sat_cnt !== 16'd2) begin
            err_cnt++;
            $display("[TB] FAIL sat_cnt_two: got %0d, expected 2", sat_cnt);
        end
        sat_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_cnt_clr = 1'b0;
        vec_cnt++;
        if (sat_cnt !== 16'd0) begin
            err_cnt++;
            $display("[TB] FAIL sat_cnt_clear: got %0d, expected 0", sat_cnt);
        end
        // Continuous saturating stream long enough to reach the counter ceiling.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 8'sd100;
        in_last = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        vec_cnt++;
        if (sat_cnt !== 16'hFFFF) begin
            err_cnt++;
            $display("[TB] FAIL sat_cnt_hold: got %0h, expected ffff", sat_cnt);
        end
        sat_cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        sat_cnt_clr = 1'b0;
        vec_cnt++;
        if (sat_cnt !== 16'd0) begin
            err_cnt++;
            $display("[TB] FAIL clr_priority: got %0d, expected 0", sat_cnt);
        end
        @(posedge clk);
        #1;
        vec_cnt++;
        if (sat_cnt !== 16'd1) begin
            err_cnt++;
            $display("[TB] FAIL count_after_clr: got %0d, expected 1", sat_cnt);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int cyc = 0;
        logic stalled = 1'b0;
        logic signed [7:0] held = '0;
        do_reset();
        fork
            begin
                for (int i = 1; i <= 20; i++) push(8'(i), 1'b0, 1'b0);
            end
            begin
                while (got < 20 && cyc < 400) begin
                    @(posedge clk);
                    #1;
                    out_ready = (cyc >= 5 && cyc < 10) ? 1'b0 : 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (stalled) begin
                        vec_cnt++;
                        if (out_valid !== 1'b1 || out_data !== held) begin
                            err_cnt++;
                            $display("[TB] FAIL stall_stable: got v%0b %0d, expected v1 %0d", out_valid, out_data, held);
                        end
                    end
                    if (cyc == 9) begin
                        vec_cnt++;
                        if (in_ready !== 1'b0) begin
                            err_cnt++;
                            $display("[TB] FAIL full_in_ready: got %0b, expected 0", in_ready);
                        end
                    end
                    if (out_valid && out_ready) begin
                        vec_cnt++;
                        if (out_data !== 8'(got + 1) || out_ch !== 2'(got % 4)) begin
                            err_cnt++;
                            $display("[TB] FAIL stream_order: got %0d ch%0d, expected %0d ch%0d",
                                     out_data, out_ch, got + 1, got % 4);
                        end
                        got++;
                    end
                    stalled = out_valid && !out_ready;
                    held = out_data;
                    cyc++;
                end
            end
        join
        vec_cnt++;
        if (got !== 20) begin
            err_cnt++;
            $display("[TB] FAIL stream_count: got %0d beats, expected 20", got);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_channels();
        logic signed [7:0] od, otd;
        logic [1:0] och, otch;
        logic osat;
        int lat;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            transact(8'(i), 1'b0, 1'b0, od, och, osat, otd, otch, lat);
            vec_cnt++;
            if (och !== 2'(i % 4)) begin
                err_cnt++;
                $display("[TB] FAIL ch_seq_%0d: got ch%0d, expected ch%0d", i, och, i % 4);
            end
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            transact(8'(i), 1'(i % 2), 1'b0, od, och, osat, otd, otch, lat);
            vec_cnt++;
            if (och !== 2'(i % 2)) begin
                err_cnt++;
                $display("[TB] FAIL ch_last_%0d: got ch%0d, expected ch%0d", i, och, i % 2);
            end
        end
        transact(8'sd1, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        transact(8'sd2, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        cfg_sel = 1'b0;
        cfg_ch = 2'd2;
        cfg_data = 8'sh20;
        transact(8'sd10, 1'b0, 1'b1, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd10 || och !== 2'd2) begin
            err_cnt++;
            $display("[TB] FAIL cfg_same_cycle: got %0d ch%0d, expected 10 ch2", od, och);
        end
        transact(8'sd0, 1'b1, 1'b0, od, och, osat, otd, otch, lat);
        transact(8'sd0, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        transact(8'sd0, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        transact(8'sd10, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd20 || och !== 2'd2) begin
            err_cnt++;
            $display("[TB] FAIL cfg_next_beat: got %0d ch%0d, expected 20 ch2", od, och);
        end
    endtask

    task automatic test_async_reset();
        logic signed [7:0] od, otd;
        logic [1:0] och, otch;
        logic osat;
        int lat;
        logic seen = 1'b0;
        write_coef(1'b0, 2'd0, 8'sh20);
        out_ready = 1'b0;
        push(8'sd5, 1'b0, 1'b0);
        push(8'sd6, 1'b0, 1'b0);
        vec_cnt++;
        if (out_valid !== 1'b1) begin
            err_cnt++;
            $display("[TB] FAIL prereset_valid: got %0b, expected 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || out_data !== 8'sd0) begin
            err_cnt++;
            $display("[TB] FAIL async_drop: got v%0b %0d, expected v0 0", out_valid, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        vec_cnt++;
        if (seen !== 1'b0) begin
            err_cnt++;
            $display("[TB] FAIL ghost_output: got out_valid 1, expected 0");
        end
        transact(8'sd25, 1'b0, 1'b0, od, och, osat, otd, otch, lat);
        vec_cnt++;
        if (od !== 8'sd25 || och !== 2'd0) begin
            err_cnt++;
            $display("[TB] FAIL post_reset_25: got %0d ch%0d, expected 25 ch0", od, och);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_sel = 1'b0;
        cfg_ch = '0;
        cfg_data = '0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        sat_cnt_clr = 1'b0;
        test_reset();
        test_coef();
        test_saturation();
        test_back_to_back();
        test_channels();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
